ps2_mouse_packet_rx: RTL

Receive front end for the PS/2 mouse path, upstream of the mouse position/click logic that drives the processor's mouse inputs.
- Samples raw ps2_clk/ps2_data from a PMOD pin pair, deglitches the PS/2 clock and deframes 11-bit device-to-host frames.
- Assembles standard 3-byte mouse packets and emits signed deltas plus button state as a one-cycle-valid record.
- One instance per mouse, running on the 100 MHz buffered system clock.

---
 rtl/ps2_mouse_packet_rx.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx
//   Receive front end for one PS/2 mouse. Synchronises the raw PS/2 pin pair,
//   deglitches the PS/2 clock, deframes 11-bit device-to-host frames
//   (start, 8 data LSB-first, odd parity, stop) and assembles the standard
//   3-byte mouse packet into signed deltas plus button state.
//
// Ports:
//   clk_in       system clock (100 MHz)
//   rst_in       synchronous active-low reset
//   ps2_clk      raw PS/2 clock, asynchronous to clk_in
//   ps2_data     raw PS/2 data, asynchronous to clk_in
//   packet_valid one-cycle pulse: dx/dy/buttons/ovf carry a new packet
//   dx, dy       signed 9-bit deltas {sign, byte}; dy positive = up
//   btn_left/right/middle  button state from header byte bits 0/1/2
//   ovf          {y_ovf, x_ovf} from header byte bits 7:6
//   frame_err    one-cycle pulse on parity/stop error or mid-frame timeout
//
// Output handshake: there is no back-pressure. packet_valid is high for
// exactly one clk_in cycle per packet and the consumer must take
// dx/dy/buttons/ovf in that cycle; those outputs then hold until the next
// packet. frame_err is an independent one-cycle event pulse.

module ps2_mouse_packet_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       packet_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic [1:0] ovf,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (idle-high lines, so reset to 1)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_bit;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock deglitch filter: the filtered clock only follows the synced
    // clock after FILTER_LEN consecutive disagreeing samples.
    // ------------------------------------------------------------------
    logic [FCW-1:0] filt_cnt;
    logic           filt_clk;
    logic           filt_clk_d;
    logic           fall_tick;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s != filt_clk) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall_tick = filt_clk_d & ~filt_clk;

    // ------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       parity_ok;
    logic [1:0] idx;
    logic       busy;
    logic       timeout_fire;
    logic [TCW-1:0] to_cnt;

    logic shift_en;
    logic parity_cap;
    logic stop_eval;
    logic cnt_clr;
    logic byte_ok;
    logic byte_bad;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_fire) begin
            state_d = S_IDLE;
        end else if (fall_tick) begin
            case (state_q)
                S_IDLE:   if (!data_bit) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // A fall_tick coinciding with a timeout is dropped entirely.
    always_comb begin
        shift_en   = 1'b0;
        parity_cap = 1'b0;
        stop_eval  = 1'b0;
        cnt_clr    = 1'b0;
        if (fall_tick && !timeout_fire) begin
            case (state_q)
                S_IDLE:   cnt_clr    = !data_bit;
                S_DATA:   shift_en   = 1'b1;
                S_PARITY: parity_cap = 1'b1;
                S_STOP:   stop_eval  = 1'b1;
                default:  cnt_clr    = 1'b0;
            endcase
        end
    end

    assign byte_ok  = stop_eval & data_bit & parity_ok;
    assign byte_bad = stop_eval & ~(data_bit & parity_ok);

    // Frame datapath: LSB-first shift and odd-parity capture
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            parity_ok <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end
            if (shift_en) begin
                shreg   <= {data_bit, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (parity_cap) begin
                parity_ok <= ^{shreg, data_bit};
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout: only armed while a frame or a packet is in progress
    // ------------------------------------------------------------------
    assign busy         = (state_q != S_IDLE) || (idx != 2'd0);
    assign timeout_fire = busy && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            to_cnt <= '0;
        end else if (!busy || fall_tick || timeout_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Packet assembly. Only the header bits that reach an output are kept:
    // hdr = {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}.
    // ------------------------------------------------------------------
    logic [6:0] hdr;
    logic [7:0] byte1;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx   <= 2'd0;
            hdr   <= '0;
            byte1 <= '0;
        end else if (timeout_fire || byte_bad) begin
            idx <= 2'd0;
        end else if (byte_ok) begin
            case (idx)
                2'd0: begin
                    // Header bit3 is always 1; a byte without it is a
                    // misaligned byte and is dropped to resynchronise.
                    if (shreg[3]) begin
                        hdr <= {shreg[7:4], shreg[2:0]};
                        idx <= 2'd1;
                    end
                end
                2'd1: begin
                    byte1 <= shreg;
                    idx   <= 2'd2;
                end
                default: idx <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            packet_valid <= 1'b0;
            frame_err    <= 1'b0;
            dx           <= '0;
            dy           <= '0;
            btn_left     <= 1'b0;
            btn_right    <= 1'b0;
            btn_middle   <= 1'b0;
            ovf          <= '0;
        end else begin
            packet_valid <= byte_ok && (idx == 2'd2);
            // Timeout between frames (FSM idle) is a silent resync.
            frame_err    <= byte_bad || (timeout_fire && (state_q != S_IDLE));
            if (byte_ok && (idx == 2'd2)) begin
                dx         <= {hdr[3], byte1};
                dy         <= {hdr[4], shreg};
                btn_left   <= hdr[0];
                btn_right  <= hdr[1];
                btn_middle <= hdr[2];
                ovf        <= hdr[6:5];
            end
        end
    end

endmodule
